// File: rtl/ps2_dev_tx_fifo.sv
// ps2_dev_tx_fifo: queued PS/2 device transmitter with clock divider, gap insertion and inhibit retry.
// Latency: wr_en in cycle N into an idle, empty block drives the start bit in cycle N+2.
// Backpressure: full blocks further writes (dropped); host inhibit aborts and retries the head byte.

module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk_25mhz,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module ps2_dev_tx_fifo #(
   parameter int CLK_DIV    = 1000,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_HALFS  = 1023
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [8:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       sent,
   output logic       aborted,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);
   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int GW = $clog2(GAP_HALFS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_HALFS - 1);
   // Bit index 11 marks the trailing released-clock half after the stop bit.
   localparam logic [3:0] BIT_TAIL = 4'd11;

   typedef enum logic [2:0] {IDLE, GAP, HIGH, LOW, INHIBIT} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    head;
   logic          half_end;
   logic          line_idle;
   logic          pop;

   function automatic logic bit_oe(input logic [3:0] idx, input logic [7:0] b);
      logic v;
      if (idx == 4'd0)       v = 1'b0;
      else if (idx <= 4'd8)  v = b[3'(idx - 4'd1)];
      else if (idx == 4'd9)  v = ~^b;
      else                   v = 1'b1;
      return ~v;
   endfunction

   assign half_end  = (presc == PRESC_LAST);
   assign line_idle = ps2_clk_in && ps2_data_in;
   assign pop       = (state == HIGH) && (bit_cnt == BIT_TAIL) && half_end && !reset;
   assign busy      = (state != IDLE);

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .push      (wr_en),
      .push_dat  (wr_data),
      .pop       (pop),
      .head_dat  (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state       <= IDLE;
         presc       <= '0;
         gap_cnt     <= '0;
         bit_cnt     <= '0;
         sent        <= 1'b0;
         aborted     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         sent    <= 1'b0;
         aborted <= 1'b0;

         // While inhibited the prescaler measures continuous clock-high time.
         if (state == IDLE || (state == INHIBIT && !ps2_clk_in) || half_end)
            presc <= '0;
         else
            presc <= presc + 1'b1;

         case (state)
            IDLE: begin
               if (!empty && line_idle) begin
                  gap_cnt <= '0;
                  bit_cnt <= '0;
                  if (head[8]) begin
                     state <= GAP;
                  end else begin
                     state       <= HIGH;
                     ps2_data_oe <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (half_end) begin
                  if (gap_cnt == GAP_LAST) begin
                     state       <= HIGH;
                     ps2_data_oe <= 1'b1;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
            end
            HIGH: begin
               if (half_end) begin
                  if (bit_cnt == BIT_TAIL) begin
                     sent    <= 1'b1;
                     bit_cnt <= '0;
                     state   <= IDLE;
                  end else if (!ps2_clk_in) begin
                     aborted     <= 1'b1;
                     ps2_data_oe <= 1'b0;
                     state       <= INHIBIT;
                  end else begin
                     ps2_clk_oe <= 1'b1;
                     state      <= LOW;
                  end
               end
            end
            LOW: begin
               if (half_end) begin
                  ps2_clk_oe  <= 1'b0;
                  bit_cnt     <= bit_cnt + 4'd1;
                  ps2_data_oe <= bit_oe(bit_cnt + 4'd1, head[7:0]);
                  state       <= HIGH;
               end
            end
            INHIBIT: begin
               if (half_end && ps2_clk_in) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_dev_tx_fifo.sv
// Randomized scoreboard bench for ps2_dev_tx_fifo: a queue model predicts bytes and FIFO
// occupancy, a frame monitor decodes the open-drain lines and checks timing and content.
module tb_ps2_dev_tx_fifo;
   localparam int CLK_DIV   = 4;
   localparam int DEPTH     = 4;
   localparam int GAP_HALFS = 5;

   logic       clk_25mhz = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [8:0] wr_data = '0;
   logic       full, empty, busy, sent, aborted;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       host_clk_low = 1'b0;
   logic       host_data_low = 1'b0;

   // Open-drain wired-AND of device and host drivers.
   assign ps2_clk_in  = ~(ps2_clk_oe | host_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | host_data_low);

   always #5 clk_25mhz = ~clk_25mhz;

   ps2_dev_tx_fifo #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH),
      .GAP_HALFS  (GAP_HALFS)
   ) dut (
      .clk_25mhz   (clk_25mhz),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .empty       (empty),
      .busy        (busy),
      .sent        (sent),
      .aborted     (aborted),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted bytes in write order and FIFO occupancy.
   logic [8:0] exp_q[$];
   int         mcnt = 0;
   bit         armed = 1'b0;

   initial begin
      logic acc;
      forever begin
         @(posedge clk_25mhz);
         acc = wr_en && !reset && (mcnt < DEPTH);
         if (acc) exp_q.push_back(wr_data);
         #1;
         if (reset) begin
            mcnt = 0;
            exp_q.delete();
         end else if (armed) begin
            mcnt = mcnt + int'(acc) - int'(sent);
            chk("full_flag", full, mcnt == DEPTH);
            chk("empty_flag", empty, mcnt == 0);
         end
      end
   end

   // Monitor: decodes frames from the line drivers and checks against the model.
   int          cyc = 0;
   bit          in_frame = 1'b0;
   int          start_cyc = 0, nb = 0, lo_start = 0;
   int          last_sent_cyc = -1, gap_obs = -1;
   int          n_sent = 0, n_abort = 0, n_start = 0;
   logic [10:0] bits = '0;
   logic        p_clk = 1'b0, p_dat = 1'b0;

   initial begin
      logic [8:0] e;
      logic [7:0] b;
      forever begin
         @(posedge clk_25mhz);
         #2;
         cyc++;
         if (!armed) continue;
         if (reset) begin
            in_frame = 1'b0;
            p_clk    = 1'b0;
            p_dat    = 1'b0;
            continue;
         end
         if (ps2_data_oe && !p_dat && !in_frame) begin
            in_frame  = 1'b1;
            start_cyc = cyc;
            nb        = 0;
            n_start++;
            gap_obs = (last_sent_cyc < 0) ? -1 : cyc - last_sent_cyc;
            if (exp_q.size() > 0 && !exp_q[0][8])
               chk("start_only_when_lines_idle", {host_clk_low, host_data_low}, 0);
         end
         if (ps2_clk_oe && !p_clk) begin
            chk("clk_pulse_in_frame", in_frame && nb <= 10, 1);
            if (in_frame && nb <= 10) begin
               chk("clk_fall_time", cyc - start_cyc, (2 * nb + 1) * CLK_DIV);
               bits[nb] = !ps2_data_oe;
               nb++;
               lo_start = cyc;
            end
         end
         if (!ps2_clk_oe && p_clk && in_frame)
            chk("clk_low_width", cyc - lo_start, CLK_DIV);
         if (aborted) begin
            n_abort++;
            chk("abort_releases_lines", {ps2_clk_oe, ps2_data_oe}, 0);
            in_frame = 1'b0;
         end
         if (sent) begin
            chk("sent_ends_full_frame", in_frame && nb == 11, 1);
            chk("frame_length", cyc - start_cyc, 23 * CLK_DIV);
            chk("data_released_at_sent", ps2_data_oe, 0);
            chk("sent_has_expected_byte", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               b = bits[8:1];
               chk("start_bit", bits[0], 0);
               chk("stop_bit", bits[10], 1);
               chk("parity_bit", bits[9], ~^b);
               chk("frame_byte", b, e[7:0]);
            end
            last_sent_cyc = cyc;
            n_sent++;
            in_frame = 1'b0;
         end
         p_clk = ps2_clk_oe;
         p_dat = ps2_data_oe;
      end
   end

   task automatic push(input logic [8:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      @(negedge clk_25mhz);
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int t;
      t = 0;
      while ((mcnt != 0 || busy || in_frame) && t < budget) begin
         @(negedge clk_25mhz);
         t++;
      end
      chk("drain_within_budget", t < budget, 1);
   endtask

   task automatic wait_bit(input int want, input int budget);
      int t;
      t = 0;
      while (!(in_frame && nb == want && !ps2_clk_oe) && t < budget) begin
         @(negedge clk_25mhz);
         t++;
      end
      chk("reach_bit_high_half", t < budget, 1);
   endtask

   initial begin
      repeat (90000) @(posedge clk_25mhz);
      $display("FAIL watchdog: run exceeded cycle budget (%0d vectors, %0d miscompares)", n_vec, n_err);
      $fatal(1);
   end

   initial begin
      int s0, t0, a0, t, n;
      repeat (2) @(negedge clk_25mhz);
      armed = 1'b1;
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sent", sent, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      reset = 1'b0;
      @(negedge clk_25mhz);

      // First-byte latency and frame content for 0x1C.
      t0 = n_sent;
      wr_data = 9'h01C;
      wr_en   = 1'b1;
      @(posedge clk_25mhz); #1;
      chk("start_not_at_n_plus_1", ps2_data_oe, 0);
      @(negedge clk_25mhz);
      wr_en = 1'b0;
      @(posedge clk_25mhz); #1;
      chk("start_at_n_plus_2", ps2_data_oe, 1);
      wait_drain(400);
      chk("frame_1c_sent", n_sent - t0, 1);
      chk("frame_1c_bits", bits, 11'b100_0011_1000);

      // Back-to-back 0x00 and 0xFF.
      t0 = n_sent;
      push(9'h000);
      push(9'h0FF);
      wait_drain(600);
      chk("b2b_sent_count", n_sent - t0, 2);
      chk("b2b_no_gap", gap_obs, 1);
      chk("parity_ff", bits[9], 1);

      // Overflow while host holds data low.
      host_data_low = 1'b1;
      s0 = n_start;
      t0 = n_sent;
      for (int i = 0; i <= DEPTH; i++) begin
         push({1'b0, 8'(8'h30 + i)});
         if (i == DEPTH - 1) chk("full_after_depth_writes", full, 1);
      end
      repeat (40) @(negedge clk_25mhz);
      chk("rts_no_line_activity", n_start - s0, 0);
      chk("rts_not_busy", busy, 0);
      host_data_low = 1'b0;
      wait_drain(DEPTH * 150 + 100);
      chk("overflow_frame_count", n_sent - t0, DEPTH);

      // Gap before a flagged byte.
      push(9'h0F0);
      push(9'h11C);
      wait_drain(700);
      chk("gap_cycles", gap_obs, GAP_HALFS * CLK_DIV + 1);

      // Host inhibit during the HIGH half of bit 4 of 0xAA.
      a0 = n_abort;
      t0 = n_sent;
      push(9'h0AA);
      wait_bit(4, 400);
      host_clk_low = 1'b1;
      t = 0;
      while (n_abort == a0 && t < 4 * CLK_DIV) begin
         @(negedge clk_25mhz);
         t++;
      end
      chk("abort_pulse_seen", n_abort - a0, 1);
      chk("abort_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
      s0 = n_start;
      repeat (3 * CLK_DIV) @(negedge clk_25mhz);
      chk("inhibit_busy", busy, 1);
      chk("inhibit_no_restart", n_start - s0, 0);
      chk("inhibit_byte_kept", empty, 0);
      host_clk_low = 1'b0;
      wait_drain(500);
      chk("retx_sent_once", n_sent - t0, 1);
      chk("abort_once", n_abort - a0, 1);
      chk("retx_byte", bits[8:1], 8'hAA);

      // Reset during bit 6.
      t0 = n_sent;
      push(9'h05A);
      push(9'h021);
      wait_bit(6, 400);
      reset = 1'b1;
      @(posedge clk_25mhz); #1;
      chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_empty", empty, 1);
      @(negedge clk_25mhz);
      reset = 1'b0;
      repeat (200) @(negedge clk_25mhz);
      chk("midrst_no_sent", n_sent - t0, 0);
      chk("midrst_idle", busy, 0);

      // Randomized traffic with occasional host request-to-send holds.
      for (int it = 0; it < 25; it++) begin
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++)
            push({($urandom_range(0, 3) == 0), 8'($urandom)});
         if ($urandom_range(0, 4) == 0) begin
            host_data_low = 1'b1;
            repeat ($urandom_range(1, 150)) @(negedge clk_25mhz);
            host_data_low = 1'b0;
         end
         repeat ($urandom_range(0, 150)) @(negedge clk_25mhz);
      end
      wait_drain(3000);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
